// File: rtl/gate_truth_checker_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by {A,B}: bit 0 is A=0,B=0 and bit 3 is A=1,B=1.
package gate_truth_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_truth_checker_dwell_counter.sv
// Dwell counter: counts enabled cycles, flags the last cycle of a DWELL-long hold.
// clear has priority over enable; tc is a plain compare so callers decide when it matters.
module gate_truth_checker_dwell_counter #(
    parameter int DWELL = 200,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/gate_truth_checker.sv
// Applies 00,01,10,11 to a 2-input gate, holding each for DWELL cycles, and checks
// the gate's Y at the last cycle of each hold against TRUTH.
module gate_truth_checker
    import gate_truth_checker_pkg::*;
#(
    parameter int         DWELL = 200,
    parameter int         CNT_W = 8,
    parameter logic [3:0] TRUTH = TT_XNOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    if (DWELL < 2) begin : g_dwell_too_small
        $error("gate_truth_checker: DWELL must be >= 2");
    end
    if ((2 ** CNT_W) < DWELL) begin : g_cnt_too_narrow
        $error("gate_truth_checker: CNT_W too narrow for DWELL");
    end

    // Handshake: start (pulse or level) is accepted only in IDLE or DONE and is ignored
    // while busy; done is a one-cycle strobe, after which pass/err_* hold until the next run.
    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] mask_n;
    logic [2:0] count_n;
    logic       pass_n;
    logic       cnt_clear;
    logic       tc;

    gate_truth_checker_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (state == DRIVE),
        .tc     (tc)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        mask_n    = err_mask;
        count_n   = err_count;
        pass_n    = pass;
        cnt_clear = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = DRIVE;
                    idx_n     = 2'd0;
                    mask_n    = 4'b0000;
                    count_n   = 3'd0;
                    pass_n    = 1'b0;
                    cnt_clear = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            DRIVE: begin
                if (tc) begin
                    cnt_clear = 1'b1;
                    if (y_in != TRUTH[idx]) begin
                        mask_n[idx] = 1'b1;
                        count_n     = err_count + 3'd1;
                    end
                    if (idx == 2'd3) begin
                        state_n = DONE;
                        pass_n  = (count_n == 3'd0);
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= 4'b0000;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            a_out     <= (state_n == DRIVE) ? idx_n[1] : 1'b0;
            b_out     <= (state_n == DRIVE) ? idx_n[0] : 1'b0;
            busy      <= (state_n == DRIVE);
            done      <= (state_n == DONE);
            pass      <= pass_n;
            err_count <= count_n;
            err_mask  <= mask_n;
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker with DWELL=4: a bench-side gate model drives y_in,
// and a second instance with TRUTH=XOR is wired to a real XOR of its own outputs.
module tb_gate_truth_checker;
    import gate_truth_checker_pkg::*;

    localparam int DW  = 4;
    localparam int RUN = NUM_VEC * DW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       glitch = 1'b0;
    logic [3:0] gate_tt = TT_XNOR;

    logic       a_out, b_out, y_in, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;

    logic       a_x, b_x, y_x, busy_x, done_x, pass_x;
    logic [2:0] err_count_x;
    logic [3:0] err_mask_x;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign y_in = gate_tt[{a_out, b_out}] ^ glitch;
    assign y_x  = a_x ^ b_x;

    gate_truth_checker #(.DWELL(DW), .CNT_W(3), .TRUTH(TT_XNOR)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .a_out (a_out), .b_out (b_out), .y_in (y_in),
        .busy (busy), .done (done), .pass (pass),
        .err_count (err_count), .err_mask (err_mask)
    );

    gate_truth_checker #(.DWELL(DW), .CNT_W(3), .TRUTH(TT_XOR)) u_dut_x (
        .clk (clk), .rst_n (rst_n), .start (start),
        .a_out (a_x), .b_out (b_x), .y_in (y_x),
        .busy (busy_x), .done (done_x), .pass (pass_x),
        .err_count (err_count_x), .err_mask (err_mask_x)
    );

    // Reference: vector i mismatches when the gate's settled output differs from the table.
    function automatic logic [3:0] model_mask(input logic [3:0] gate, input logic [3:0] truth);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (gate[i] != truth[i]) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2:0] model_count(input logic [3:0] m);
        int n;
        n = 0;
        for (int i = 0; i < NUM_VEC; i++) n += int'(m[i]);
        return 3'(n);
    endfunction

    task automatic test_reset();
        logic [11:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        obs = {a_out, b_out, busy, done, pass, err_count, err_mask};
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL reset_state outputs=%b expected all zero", obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {a_out, b_out, busy, done, pass, err_count, err_mask};
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL reset_release outputs=%b expected all zero", obs);
        end
    endtask

    // One full run from a negedge in IDLE; optional start re-pulses, glitches and a
    // start held into the DONE cycle.
    task automatic run_check(input string name, input logic [3:0] tt, input bit glitch_en,
                             input bit repulse, input bit hold_start);
        logic [3:0] em, exp_v, obs_v;
        logic [2:0] ec;
        logic [7:0] exp_r, obs_r;
        int         n;
        em    = model_mask(tt, TT_XNOR);
        ec    = model_count(em);
        gate_tt = tt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= RUN + 1; c++) begin
            glitch = glitch_en && (c <= RUN) && (((c - 1) % DW) != (DW - 1));
            start  = (repulse && (c == 3 || c == 10)) || (hold_start && c == RUN + 1);
            exp_v  = (c <= RUN) ? {2'((c - 1) / DW), 2'b10} : 4'b0001;
            obs_v  = {a_out, b_out, busy, done};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d {a,b,busy,done}=%b expected %b", name, c, obs_v, exp_v);
            end
            if (c == RUN + 1) begin
                exp_r = {(ec == 3'd0), ec, em};
                obs_r = {pass, err_count, err_mask};
                checks++;
                if (obs_r !== exp_r) begin
                    errors++;
                    $display("FAIL %s result {pass,count,mask}=%b expected %b", name, obs_r, exp_r);
                end
                obs_r = {done_x, pass_x, err_count_x, err_mask_x[2:0]};
                checks++;
                if ({obs_r, err_mask_x[3]} !== 9'b110000000) begin
                    errors++;
                    $display("FAIL %s xor_truth done=%b pass=%b count=%0d mask=%b expected 1 1 0 0000",
                             name, done_x, pass_x, err_count_x, err_mask_x);
                end
            end else begin
                @(negedge clk);
            end
        end
        glitch = 1'b0;
        @(negedge clk);
        if (hold_start) begin
            start = 1'b0;
            obs_r = {a_out, b_out, busy, done, pass, err_count[0], err_mask[1:0]};
            checks++;
            if (obs_r !== 8'b0010_0000 || err_count !== 3'd0 || err_mask !== 4'd0) begin
                errors++;
                $display("FAIL %s restart {a,b,busy,done,pass}=%b count=%0d mask=%b expected 00100 0 0000",
                         name, {a_out, b_out, busy, done, pass}, err_count, err_mask);
            end
            n = 0;
            while (!done && n < RUN + 4) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!done || n != RUN) begin
                errors++;
                $display("FAIL %s restart_done done=%b after %0d cycles expected 1 after %0d", name, done, n, RUN);
            end
            checks++;
            if ({err_count, err_mask} !== {ec, em}) begin
                errors++;
                $display("FAIL %s restart_result count=%0d mask=%b expected %0d %b", name, err_count, err_mask, ec, em);
            end
            @(negedge clk);
        end else begin
            checks++;
            if ({busy, done, pass, err_count, err_mask} !== {2'b00, (ec == 3'd0), ec, em}) begin
                errors++;
                $display("FAIL %s after_done busy=%b done=%b pass=%b count=%0d mask=%b expected 0 0 %b %0d %b",
                         name, busy, done, pass, err_count, err_mask, (ec == 3'd0), ec, em);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] obs;
        gate_tt = TT_XNOR;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({a_out, b_out, busy} !== 3'b101) begin
            errors++;
            $display("FAIL mid_run_pre_reset {a,b,busy}=%b expected 101", {a_out, b_out, busy});
        end
        rst_n = 1'b0;
        #1;
        obs = {a_out, b_out, busy, done, pass, err_count, err_mask};
        checks++;
        if (obs !== 12'd0 || busy_x !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset outputs=%b busy_x=%b expected all zero", obs, busy_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = {a_out, b_out, busy, done, pass, err_count, err_mask};
            checks++;
            if (obs !== 12'd0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d outputs=%b expected all zero", k, obs);
            end
        end
        run_check("clean_after_reset", TT_XNOR, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] tt;
        bit         g;
        for (int r = 0; r < 6; r++) begin
            tt = 4'($urandom_range(0, 15));
            g  = 1'($urandom_range(0, 1));
            run_check("random", tt, g, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_check("good_gate", TT_XNOR, 1'b0, 1'b0, 1'b0);
        run_check("y_tied_0", 4'b0000, 1'b0, 1'b0, 1'b0);
        run_check("xor_gate", TT_XOR, 1'b0, 1'b0, 1'b0);
        run_check("start_repulse", TT_XNOR, 1'b0, 1'b1, 1'b0);
        run_check("start_held", 4'b0000, 1'b0, 1'b0, 1'b1);
        test_reset_mid_run();
        run_check("glitch", TT_XNOR, 1'b1, 1'b0, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Sequential stimulus-and-check stage wrapped around any 2-input gate under test (xnor_gate by default).
- Drives the gate's A/B inputs through 00, 01, 10, 11, holding each vector for DWELL cycles.
- Samples the gate's Y output at the end of each dwell and compares it against a parameterised truth table.
- Reports a pass/fail flag, a per-vector error mask and an error count, so gate checks run in hardware or in a bench without hand-written timing.

Parameters:
- DWELL, 200: clock cycles each vector is held. Must be >= 2; elaboration fails otherwise.
- CNT_W, 8: width of the dwell counter. Must satisfy 2**CNT_W >= DWELL.
- TRUTH, 4'b1001: expected Y, indexed by {A,B}. Default is XNOR: TRUTH[0] is for A=0,B=0 and TRUTH[3] is for A=1,B=1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, single-cycle pulse or level
- a_out  out  1  drives A of the gate under test
- b_out  out  1  drives B of the gate under test
- y_in  in  1  Y from the gate under test
- busy  out  1  high while vectors are being applied
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  1 when the last run had zero mismatches
- err_count  out  3  number of mismatching vectors, 0..4
- err_mask  out  4  bit i set when vector {A,B}=i mismatched

Behaviour:
- Reset: one clock, asynchronous, active-low. Asserting rst_n low forces state IDLE and all outputs to 0 (a_out, b_out, busy, done, pass, err_count, err_mask), plus idx=0 and cnt=0. Takes effect immediately, including mid-run. No partial results are retained.
- State machine: IDLE, DRIVE, DONE.
- IDLE: a_out=b_out=0, busy=0.
  - start=1 clears err_mask, err_count and pass, sets idx=0 and cnt=0, and moves to DRIVE.
- DRIVE: busy=1, {a_out,b_out}=idx, registered.
  - cnt increments every cycle.
  - When cnt==DWELL-1: sample y_in. If y_in != TRUTH[idx], set err_mask[idx] and increment err_count. Then clear cnt.
    - If idx==3, go to DONE.
    - Otherwise idx = idx+1 and stay in DRIVE.
- DONE: busy=0, a_out=b_out=0, done=1 for this cycle only, pass = (err_count==0) including any update from the final sample.
  - start=1 here behaves as in IDLE: a new run begins and DRIVE follows.
  - Otherwise go to IDLE.
- Latency:
  - start sampled at edge 0.
  - Vector i is on a_out/b_out for cycles 1+i*DWELL through (i+1)*DWELL.
  - done is high in cycle 4*DWELL+1.
- y_in is expected to settle combinationally within the dwell. It is sampled only at the last dwell cycle, so glitches earlier in the dwell are ignored.
- start while busy=1 is ignored. err_count saturates naturally at 4.
- pass, err_mask and err_count hold their values after DONE until the next accepted start or reset.

Decomposition:
- Shared package/header:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2)
  - NUM_VEC=4
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_XNOR=4'b1001, TT_NAND=4'b0111, TT_NOR=4'b0001
- Sub-module: dwell_counter (clear, enable, terminal-count flag at DWELL-1). Reused by later timed stimulus blocks.

Test Plan:
All scenarios use DWELL=4 with the checker wired to xnor_gate unless stated.
- Good gate: pulse start -> {a_out,b_out} = 00,01,10,11, each for exactly 4 cycles; done at cycle 17; pass=1, err_mask=4'b0000, err_count=0.
- y_in tied to 0 -> err_mask=4'b1001, err_count=2, pass=0.
- xor_gate substituted, TRUTH left at XNOR -> err_mask=4'b1111, err_count=4, pass=0. Repeat with TRUTH=TT_XOR -> pass=1.
- start re-pulsed at cycles 3 and 10 -> ignored; done still at cycle 17, single pulse. start held high through the DONE cycle -> a new run begins, busy=1 in cycle 18, and err fields are cleared.
- rst_n low in cycle 9 (during vector 10) -> all outputs 0 the same cycle. After release, state is IDLE with no done. A following start gives a full clean run.
- y_in glitching to wrong value in dwell cycles 1-3 but correct in cycle 4 -> no error recorded.
